add32_seq: RTL and testbench

Two-pass 32-bit add sequencer that sits directly upstream of the 16-bit inverted-carry adder slice. It accepts a 32-bit operand pair, drives the low halves and then the high halves through the external adder, and feeds the registered low-half carry back as the high-half carry-in. It handles the adder's active-low carry convention at both ends and presents a true-polarity 32-bit sum and carry to its client.

---
 rtl/add32_seq.sv | 117 +++++++++++
 tb/tb_add32_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add32_seq.sv
// Two-pass 32-bit add sequencer feeding an external 16-bit inverted-carry adder slice.
// Optional subtract support is compiled in when ADD32_SUB_EN is defined.
module add32_seq #(
  parameter bit IDLE_HOLD = 1'b0
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        req,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef ADD32_SUB_EN
  input  logic        sub,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        cout,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_ci_n,
  input  logic [15:0] add_s,
  input  logic        add_co_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] ra_reg, rb_reg, sum_reg;
  logic [15:0] hold_a_reg, hold_b_reg;
  logic        rsub_reg, cy_reg, cout_reg, done_reg;
  logic        sub_sel;

`ifdef ADD32_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Adder operands are decoded straight from state so the external adder sees them in the same cycle.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    add_a      = IDLE_HOLD ? hold_a_reg : 16'd0;
    add_b      = IDLE_HOLD ? hold_b_reg : 16'd0;
    add_ci_n   = 1'b1;
    unique case (state_reg)
      IDLE: begin
        if (req) state_next = LO;
      end
      LO: begin
        busy       = 1'b1;
        add_a      = ra_reg[15:0];
        add_b      = rb_reg[15:0];
        add_ci_n   = ~rsub_reg;
        state_next = HI;
      end
      HI: begin
        busy       = 1'b1;
        add_a      = ra_reg[31:16];
        add_b      = rb_reg[31:16];
        add_ci_n   = ~cy_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_reg  <= IDLE;
      ra_reg     <= 32'd0;
      rb_reg     <= 32'd0;
      rsub_reg   <= 1'b0;
      cy_reg     <= 1'b0;
      sum_reg    <= 32'd0;
      cout_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hold_a_reg <= 16'd0;
      hold_b_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (req) begin
            ra_reg   <= a;
            rb_reg   <= sub_sel ? ~b : b;
            rsub_reg <= sub_sel;
          end
        end
        LO: begin
          sum_reg[15:0] <= add_s;
          cy_reg        <= ~add_co_n;
          hold_a_reg    <= add_a;
          hold_b_reg    <= add_b;
        end
        HI: begin
          sum_reg[31:16] <= add_s;
          cout_reg       <= ~add_co_n;
          done_reg       <= 1'b1;
          hold_a_reg     <= add_a;
          hold_b_reg     <= add_b;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_add32_seq.sv
// Self-checking bench for add32_seq: models the external inverted-carry adder slice and
// compares against plain 32-bit arithmetic (subtract cases when ADD32_SUB_EN is defined).
module tb_add32_seq;

  logic        sys_clk;
  logic        resetl;
  logic        req;
  logic [31:0] a, b;
`ifdef ADD32_SUB_EN
  logic        sub;
`endif
  logic        busy, done, cout;
  logic [31:0] sum;
  logic [15:0] add_a, add_b, add_s;
  logic        add_ci_n, add_co_n, adder_co;

  int n_checks = 0;
  int n_fail   = 0;

  add32_seq dut (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .req      (req),
    .a        (a),
    .b        (b),
`ifdef ADD32_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_ci_n (add_ci_n),
    .add_s    (add_s),
    .add_co_n (add_co_n)
  );

  // External 16-bit adder slice with active-low carry in and out.
  assign {adder_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, ~add_ci_n};
  assign add_co_n = ~adder_co;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge where done should be high.
  task automatic do_op(input logic [31:0] opa, input logic [31:0] opb, input bit s,
                       input bit hold, input bit scramble, input bit chk_lo_co);
    logic [31:0] exp_sum;
    logic        exp_cout, lo_cy;
    logic [15:0] exp_lo_b, exp_hi_b;
    if (s) begin
      exp_sum  = opa - opb;
      exp_cout = (opa >= opb);
      lo_cy    = (opa[15:0] >= opb[15:0]);
      exp_lo_b = ~opb[15:0];
      exp_hi_b = ~opb[31:16];
    end else begin
      {exp_cout, exp_sum} = {1'b0, opa} + {1'b0, opb};
      lo_cy    = ({1'b0, opa[15:0]} + {1'b0, opb[15:0]}) > 17'h0FFFF;
      exp_lo_b = opb[15:0];
      exp_hi_b = opb[31:16];
    end
    a   = opa;
    b   = opb;
    req = 1'b1;
`ifdef ADD32_SUB_EN
    sub = s;
`endif
    @(negedge sys_clk);
    check("lo_busy", busy, 1);
    check("lo_done", done, 0);
    check("lo_add_a", add_a, opa[15:0]);
    check("lo_add_b", add_b, exp_lo_b);
    check("lo_ci_n", add_ci_n, !s);
    if (chk_lo_co) check("lo_co_n", add_co_n, 0);
    req = hold;
    if (scramble) begin a = $urandom; b = $urandom; end
    @(negedge sys_clk);
    check("hi_busy", busy, 1);
    check("hi_done", done, 0);
    check("hi_add_a", add_a, opa[31:16]);
    check("hi_add_b", add_b, exp_hi_b);
    check("hi_ci_n", add_ci_n, !lo_cy);
    if (scramble) begin a = $urandom; b = $urandom; end
    @(negedge sys_clk);
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
    $display("txn a=%08h b=%08h sub=%0d sum=%08h cout=%0d exp_sum=%08h exp_cout=%0d",
             opa, opb, s, sum, cout, exp_sum, exp_cout);
  endtask

  task automatic idle_check(input string tag);
    @(negedge sys_clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_add_a"}, add_a, 0);
    check({tag, "_add_b"}, add_b, 0);
    check({tag, "_ci_n"}, add_ci_n, 1);
  endtask

  initial begin
    resetl = 1'b0;
    req    = 1'b1;
    a      = 32'hDEADBEEF;
    b      = 32'h01234567;
`ifdef ADD32_SUB_EN
    sub    = 1'b0;
`endif
    // Reset held with req high: reset wins, nothing accepted.
    repeat (3) @(negedge sys_clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_ci_n", add_ci_n, 1);
    req    = 1'b0;
    resetl = 1'b1;
    idle_check("post_rst");

    // Carry across halves, then full overflow.
    do_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    req = 1'b0;
    idle_check("after_carry");
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
    req = 1'b0;
    idle_check("after_ovf");

    // Busy isolation: operands and req disturbed during LO and HI.
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0);
    req = 1'b0;
    idle_check("iso1");
    idle_check("iso2");

    // Reset while in LO.
    a = 32'h0F0F0F0F; b = 32'h01010101; req = 1'b1;
    @(negedge sys_clk);
    check("rstlo_busy_before", busy, 1);
    resetl = 1'b0; req = 1'b0;
    @(negedge sys_clk);
    check("rstlo_busy", busy, 0);
    check("rstlo_done", done, 0);
    check("rstlo_sum", sum, 0);
    check("rstlo_cout", cout, 0);
    check("rstlo_ci_n", add_ci_n, 1);
    resetl = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("rstlo_idle");
    do_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 1'b0, 1'b0);
    req = 1'b0;
    idle_check("after_rstlo");

    // Streaming with req held high: back-to-back ops, done every third cycle.
    for (int i = 0; i < 3; i++) do_op(32'h00000002, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b0);
    req = 1'b0;
    idle_check("after_stream");

`ifdef ADD32_SUB_EN
    do_op(32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 1'b0;
    idle_check("after_sub1");
    do_op(32'd7, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 1'b0;
    idle_check("after_sub2");
`endif

    // Random operations with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      bit          rs;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) rb = ~ra;
`ifdef ADD32_SUB_EN
      rs = bit'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
      req = 1'b0;
      if ($urandom_range(0, 2) == 0) idle_check("rand_gap");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
